timer_seq_ctrl: RTL and testbench

- Programmable timer controller that sequences a cascade of NUM_STAGES 4-bit synchronous counter stages into one wide up-counter.
- Accepts a period/mode configuration through a valid/ready handshake and runs start/stop/pause control.
- Emits a one-cycle tick and a sticky interrupt at terminal count.
- Sits between the register/control logic and the counter datapath of the timer.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_digit.sv | 50 +++++
 rtl/timer_seq_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_timer_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the cascaded timer controller.
//   STAGE_W        width of one counter stage (a hex digit)
//   timer_state_e  controller FSM encoding (IDLE/RUN/PAUSE/DONE)
//   timer_mode_e   count mode (ONE_SHOT/PERIODIC)
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int STAGE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } timer_mode_e;

  // True when a stage sits at its maximum value and will carry on the next enable.
  function automatic logic stage_full(input logic [STAGE_W-1:0] v);
    return (v == {STAGE_W{1'b1}});
  endfunction

endpackage

// File: rtl/timer_digit.sv
// -----------------------------------------------------------------------------
// timer_digit
// One 4-bit synchronous up-counter stage of the timer cascade.
// Ports:
//   clk     rising-edge clock
//   clr     synchronous active-high reset (count to zero)
//   en_i    count enable (carry-in from the lower stages)
//   zero_i  synchronous load of zero, has priority over en_i
//   cnt_o   current stage value
//   tc_o    terminal carry: en_i & (cnt == 4'hF), enables the next stage
// -----------------------------------------------------------------------------
module timer_digit
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               en_i,
  input  logic               zero_i,
  output logic [STAGE_W-1:0] cnt_o,
  output logic               tc_o
);

  logic [STAGE_W-1:0] cnt_q;
  logic [STAGE_W-1:0] cnt_d;

  // Stage next value: zero load beats increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (zero_i) begin
      cnt_d = {STAGE_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + {{(STAGE_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= {STAGE_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = en_i & stage_full(cnt_q);

endmodule

// File: rtl/timer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_seq_ctrl
// Programmable timer controller: sequences NUM_STAGES cascaded 4-bit stages
// into one CW-bit up-counter, with a valid/ready configuration port,
// start/stop/pause control, a one-cycle tick and a sticky interrupt at
// terminal count.
// Ports:
//   clk, clr               clock, synchronous active-high reset
//   cfg_valid/cfg_ready    configuration handshake (ready in IDLE or DONE)
//   cfg_period, cfg_mode   terminal count P and mode (0 one-shot, 1 periodic)
//   cfg_div                prescaler divide-1 (only with TIMER_PRESCALE_EN)
//   start, stop            single-cycle start/resume and pause requests
//   cnt_out                current count
//   tick                   one-cycle pulse while cnt_out == P in RUN
//   irq, irq_ack           sticky interrupt and its clear
//   busy, state_o          RUN indicator and current FSM state
// Build option: define TIMER_PRESCALE_EN to add the cfg_div prescaler.
// -----------------------------------------------------------------------------
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter  int NUM_STAGES = 4,
  localparam int CW         = STAGE_W * NUM_STAGES
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_period,
  input  logic          cfg_mode,
`ifdef TIMER_PRESCALE_EN
  input  logic [3:0]    cfg_div,
`endif
  input  logic          start,
  input  logic          stop,
  output logic [CW-1:0] cnt_out,
  output logic          tick,
  output logic          irq,
  input  logic          irq_ack,
  output logic          busy,
  output logic [1:0]    state_o
);

  timer_state_e  state_q, state_d;
  timer_mode_e   mode_q, mode_d;
  logic [CW-1:0] period_q, period_d;
  logic          tick_q, tick_d;
  logic          irq_q, irq_d;

  logic [CW-1:0]       cnt_s;
  logic [CW-1:0]       cnt_inc_s;
  logic [NUM_STAGES:0] en_s;
  logic                cfg_ready_s;
  logic                hs_s;
  logic                run_s;
  logic                adv_s;
  logic                term_s;
  logic                inc_s;
  logic                start_ok_s;
  logic                clear_s;
  logic                zero_s;

  assign cfg_ready_s = (state_q == IDLE) || (state_q == DONE);
  assign hs_s        = cfg_valid & cfg_ready_s;
  assign run_s       = (state_q == RUN);
  assign start_ok_s  = start & (period_q != {CW{1'b0}});

  // Terminal is acted on only on an advancing clock so a prescaled count
  // dwells at P for the full division before wrapping or stopping.
  assign term_s    = run_s & adv_s & (cnt_s == period_q);
  // Stop (with or without start) suppresses counting; terminal wraps/holds.
  assign inc_s     = run_s & adv_s & ~term_s & ~stop;
  assign cnt_inc_s = cnt_s + {{(CW-1){1'b0}}, 1'b1};

`ifdef TIMER_PRESCALE_EN
  logic [3:0] div_q, div_d;
  logic [3:0] presc_q, presc_d;

  assign adv_s = (presc_q == div_q);

  // Prescaler: free-runs in RUN, holds in PAUSE/on stop, zero outside RUN/PAUSE.
  always_comb begin
    div_d   = div_q;
    presc_d = presc_q;
    if (hs_s) begin
      div_d = cfg_div;
    end else begin
      div_d = div_q;
    end
    case (state_q)
      RUN: begin
        if (stop && !term_s) begin
          presc_d = presc_q;
        end else if (adv_s) begin
          presc_d = 4'd0;
        end else begin
          presc_d = presc_q + 4'd1;
        end
      end
      PAUSE:   presc_d = presc_q;
      default: presc_d = 4'd0;
    endcase
  end

  // Prescaler and divider registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      div_q   <= 4'd0;
      presc_q <= 4'd0;
    end else begin
      div_q   <= div_d;
      presc_q <= presc_d;
    end
  end
`else
  assign adv_s = 1'b1;
`endif

  // FSM next state and the cascade zero-load request.
  always_comb begin
    state_d = state_q;
    clear_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok_s) begin
          state_d = RUN;
          clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (term_s) begin
          if (mode_q == PERIODIC) begin
            clear_s = 1'b1;
            state_d = stop ? PAUSE : RUN;
          end else begin
            state_d = DONE;
          end
        end else if (stop) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
      end
      DONE: begin
        if (start_ok_s) begin
          state_d = RUN;
          clear_s = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        clear_s = 1'b1;
      end
    endcase
  end

  // Carry out of the top stage cannot occur while cnt <= P; if it ever does,
  // force the whole cascade back to zero rather than leave a torn value.
  assign zero_s = clear_s | en_s[NUM_STAGES];

  // Config capture, tick precompute and sticky interrupt.
  always_comb begin
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    irq_d    = irq_q;
    if (hs_s) begin
      period_d = cfg_period;
      mode_d   = timer_mode_e'(cfg_mode);
    end else begin
      period_d = period_q;
      mode_d   = mode_q;
    end
    // tick is registered, so it is raised on the edge that moves cnt onto P.
    if (inc_s) begin
      tick_d = (cnt_inc_s == period_q);
    end else begin
      tick_d = 1'b0;
    end
    if (term_s) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      mode_q   <= ONE_SHOT;
      period_q <= {CW{1'b0}};
      tick_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      irq_q    <= irq_d;
    end
  end

  // Stage i counts when all lower stages are at F: en[i+1] = tc[i].
  assign en_s[0] = inc_s;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    timer_digit u_digit (
      .clk    (clk),
      .clr    (clr),
      .en_i   (en_s[i]),
      .zero_i (zero_s),
      .cnt_o  (cnt_s[i*STAGE_W +: STAGE_W]),
      .tc_o   (en_s[i+1])
    );
  end

  assign cfg_ready = cfg_ready_s;
  assign cnt_out   = cnt_s;
  assign tick      = tick_q;
  assign irq       = irq_q;
  assign busy      = run_s;
  assign state_o   = state_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
module tb_timer_seq_ctrl;

  localparam int CW = 16;

  logic          clk;
  logic          clr;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_period;
  logic          cfg_mode;
`ifdef TIMER_PRESCALE_EN
  logic [3:0]    cfg_div;
`endif
  logic          start;
  logic          stop;
  logic [CW-1:0] cnt_out;
  logic          tick;
  logic          irq;
  logic          irq_ack;
  logic          busy;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;

  timer_seq_ctrl #(.NUM_STAGES(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_mode   (cfg_mode),
`ifdef TIMER_PRESCALE_EN
    .cfg_div    (cfg_div),
`endif
    .start      (start),
    .stop       (stop),
    .cnt_out    (cnt_out),
    .tick       (tick),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .busy       (busy),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs applied before an edge, expected outputs after that edge
  typedef struct {
    logic          clr;
    logic          cv;
    logic          start;
    logic          stop;
    logic          ack;
    logic          mode;
    logic [CW-1:0] per;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic          tk;
    logic          iq;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic c, cv, s, p, a, m, input logic [CW-1:0] per,
                     input logic [1:0] st, input logic [CW-1:0] cnt, input logic tk, iq);
    vec_t v;
    v.clr = c; v.cv = cv; v.start = s; v.stop = p; v.ack = a; v.mode = m; v.per = per;
    v.st = st; v.cnt = cnt; v.tk = tk; v.iq = iq;
    vq.push_back(v);
  endtask

  task automatic cyc(input logic c, cv, s, p, a, m, input logic [CW-1:0] per);
    clr = c; cfg_valid = cv; start = s; stop = p; irq_ack = a; cfg_mode = m; cfg_period = per;
    @(posedge clk);
    #1;
    clr = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cfg_mode, cfg_period);
  endtask

  task automatic chk(input string nm, input logic [1:0] est, input logic [CW-1:0] ecnt,
                     input logic etk, input logic eiq);
    logic erdy;
    logic ebusy;
    erdy  = (est == 2'd0) || (est == 2'd3);
    ebusy = (est == 2'd1);
    checks++;
    if (state_o !== est || cnt_out !== ecnt || tick !== etk || irq !== eiq ||
        cfg_ready !== erdy || busy !== ebusy) begin
      errors++;
      $display("FAIL %s: got st=%0d cnt=%h tick=%b irq=%b rdy=%b busy=%b want st=%0d cnt=%h tick=%b irq=%b rdy=%b busy=%b",
               nm, state_o, cnt_out, tick, irq, cfg_ready, busy, est, ecnt, etk, eiq, erdy, ebusy);
    end
  endtask

  initial begin
    int n;
    clr = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
    cfg_mode = 1'b0; cfg_period = '0;
`ifdef TIMER_PRESCALE_EN
    cfg_div = 4'd0;
`endif

    //   clr cv st sp ak md per        st    cnt    tk iq
    add(1, 0, 0, 0, 0, 0, 16'd0, 2'd0, 16'd0, 0, 0);  // 0 reset
    add(0, 1, 0, 0, 0, 1, 16'd3, 2'd0, 16'd0, 0, 0);  // 1 cfg P=3 periodic
    add(0, 0, 1, 0, 0, 1, 16'd0, 2'd1, 16'd0, 0, 0);  // 2 start
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd3, 1, 0);  // 5 tick at P
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd0, 0, 1);  // 6 wrap, irq set
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd2, 0, 1);
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd3, 1, 1);  // 9 tick again
    add(0, 0, 0, 0, 1, 1, 16'd0, 2'd1, 16'd0, 0, 1);  // 10 ack with terminal: set wins
    add(0, 0, 0, 0, 1, 1, 16'd0, 2'd1, 16'd1, 0, 0);  // 11 ack clears
    add(0, 1, 0, 0, 0, 0, 16'd7, 2'd1, 16'd2, 0, 0);  // 12 cfg in RUN ignored
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd3, 1, 0);  // 13 period still 3
    add(0, 0, 1, 1, 0, 1, 16'd0, 2'd2, 16'd0, 0, 1);  // 14 start+stop at terminal
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd2, 16'd0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 16'd0, 2'd1, 16'd0, 0, 1);  // 16 resume
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd1, 0, 1);
    add(0, 0, 0, 1, 0, 1, 16'd0, 2'd2, 16'd1, 0, 1);  // 18 stop holds
    add(0, 0, 1, 1, 0, 1, 16'd0, 2'd1, 16'd1, 0, 1);  // 19 start wins in PAUSE
    add(0, 0, 0, 0, 0, 1, 16'd0, 2'd1, 16'd2, 0, 1);
    add(1, 0, 1, 0, 0, 0, 16'd0, 2'd0, 16'd0, 0, 0);  // 21 clr beats start
    add(0, 1, 0, 0, 0, 0, 16'd2, 2'd0, 16'd0, 0, 0);  // 22 cfg P=2 one-shot
    add(0, 0, 1, 0, 0, 0, 16'd0, 2'd1, 16'd0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 16'd0, 2'd1, 16'd1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 16'd0, 2'd1, 16'd2, 1, 0);
    add(0, 0, 0, 0, 0, 0, 16'd0, 2'd3, 16'd2, 0, 1);  // 26 DONE holds P
    add(0, 0, 0, 0, 0, 0, 16'd0, 2'd3, 16'd2, 0, 1);
    add(0, 1, 0, 0, 0, 0, 16'd1, 2'd3, 16'd2, 0, 1);  // 28 reload in DONE
    add(0, 0, 1, 0, 0, 0, 16'd0, 2'd1, 16'd0, 0, 1);  // 29 restart clears cnt
    add(0, 0, 0, 0, 0, 0, 16'd0, 2'd1, 16'd1, 1, 1);  // 30 new P=1 used
    add(0, 0, 0, 0, 0, 0, 16'd0, 2'd3, 16'd1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 16'd0, 2'd0, 16'd0, 0, 0);  // 32 clr
    add(0, 0, 1, 0, 0, 0, 16'd0, 2'd0, 16'd0, 0, 0);  // 33 start with P=0 ignored
    add(0, 1, 1, 0, 0, 1, 16'd5, 2'd0, 16'd0, 0, 0);  // 34 start uses old P=0
    add(0, 0, 1, 0, 0, 1, 16'd0, 2'd1, 16'd0, 0, 0);  // 35 now starts

    foreach (vq[i]) begin
      cyc(vq[i].clr, vq[i].cv, vq[i].start, vq[i].stop, vq[i].ack, vq[i].mode, vq[i].per);
      chk($sformatf("vec%0d", i), vq[i].st, vq[i].cnt, vq[i].tk, vq[i].iq);
    end

    // reset mid-run
    cyc(1, 0, 0, 0, 0, 0, 16'd0);
    cyc(0, 1, 0, 0, 0, 1, 16'd10);
    cyc(0, 0, 1, 0, 0, 1, 16'd0);
    for (int k = 0; k < 5; k++) idle_cyc();
    chk("midrun_cnt5", 2'd1, 16'd5, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0, 1, 16'd0);
    chk("midrun_clr", 2'd0, 16'd0, 1'b0, 1'b0);

    // one-shot across a stage carry
    cyc(1, 0, 0, 0, 0, 0, 16'd0);
    cyc(0, 1, 0, 0, 0, 0, 16'h0012);
    cyc(0, 0, 1, 0, 0, 0, 16'd0);
    for (int k = 0; k < 15; k++) idle_cyc();
    chk("carry_0f", 2'd1, 16'h000F, 1'b0, 1'b0);
    idle_cyc();
    chk("carry_10", 2'd1, 16'h0010, 1'b0, 1'b0);
    idle_cyc();
    idle_cyc();
    chk("oneshot_tick", 2'd1, 16'h0012, 1'b1, 1'b0);
    idle_cyc();
    chk("oneshot_done", 2'd3, 16'h0012, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      idle_cyc();
      chk($sformatf("done_hold%0d", k), 2'd3, 16'h0012, 1'b0, 1'b1);
    end

    // pause / resume
    cyc(1, 0, 0, 0, 0, 0, 16'd0);
    cyc(0, 1, 0, 0, 0, 1, 16'd100);
    cyc(0, 0, 1, 0, 0, 1, 16'd0);
    for (int k = 0; k < 40; k++) idle_cyc();
    chk("pause_at40", 2'd1, 16'd40, 1'b0, 1'b0);
    cyc(0, 0, 0, 1, 0, 1, 16'd0);
    chk("pause_enter", 2'd2, 16'd40, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      idle_cyc();
      chk($sformatf("pause_hold%0d", k), 2'd2, 16'd40, 1'b0, 1'b0);
    end
    cyc(0, 0, 1, 0, 0, 1, 16'd0);
    chk("resume_run", 2'd1, 16'd40, 1'b0, 1'b0);
    idle_cyc();
    chk("resume_41", 2'd1, 16'd41, 1'b0, 1'b0);
    cyc(0, 0, 1, 1, 0, 1, 16'd0);
    chk("run_startstop", 2'd2, 16'd41, 1'b0, 1'b0);

    // all-ones period, periodic wrap
    cyc(1, 0, 0, 0, 0, 0, 16'd0);
    cyc(0, 1, 0, 0, 0, 1, 16'hFFFF);
    cyc(0, 0, 1, 0, 0, 1, 16'd0);
    n = 0;
    while (cnt_out !== 16'hFFFF && n < 70000) begin
      idle_cyc();
      n++;
    end
    chk("allones_term", 2'd1, 16'hFFFF, 1'b1, 1'b0);
    idle_cyc();
    chk("allones_wrap", 2'd1, 16'h0000, 1'b0, 1'b1);

`ifdef TIMER_PRESCALE_EN
    // prescaler: div=2, P=2 periodic -> count every 3 clocks, tick every 9
    cyc(1, 0, 0, 0, 0, 0, 16'd0);
    cfg_div = 4'd2;
    cyc(0, 1, 0, 0, 0, 1, 16'd2);
    cfg_div = 4'd0;
    cyc(0, 0, 1, 0, 0, 1, 16'd0);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("presc%0d", k), 2'd1, CW'((k / 3) % 3), ((k % 9) == 6), (k >= 9));
      idle_cyc();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
